// File: rtl/bus_rx_fifo_pkg.sv
// bus_rx_fifo_pkg: shared sizing for the bus receive FIFO
package bus_rx_fifo_pkg;
  localparam int BUS_W = 8;
  localparam int RX_FIFO_DEPTH = 4;
  localparam int RX_FIFO_AW = 2;
endpackage

// File: rtl/bus_rx_fifo_rx_ptr.sv
// rx_ptr: AW-bit wrapping pointer with increment enable
module rx_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  logic [AW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = inc ? ptr_q + AW'(1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: captures strobed bus bytes into a show-ahead FIFO with sticky overflow
module bus_rx_fifo
  import bus_rx_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_W,
  parameter int DEPTH = RX_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_ld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d, push, pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign out_valid = ~empty;
  assign count = count_q;
  assign overflow = ovf_q;
  assign out_data = out_valid ? mem_q[rd_ptr] : '0;
  assign pop = out_valid & out_ready;
  assign push = bus_ld & (~full | pop);
  always_comb begin
    count_d = (push & ~pop) ? count_q + (AW+1)'(1) : (pop & ~push) ? count_q - (AW+1)'(1) : count_q;
    ovf_d = (bus_ld & full & ~pop) | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  // storage is deliberately left unreset; out_data masks it while empty
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr] <= bus_data;
  rx_ptr #(.AW(AW)) u_wr (.clk(clk), .rst_n(rst_n), .inc(push), .ptr(wr_ptr));
  rx_ptr #(.AW(AW)) u_rd (.clk(clk), .rst_n(rst_n), .inc(pop), .ptr(rd_ptr));
endmodule
